bram_reader_2out: RTL and testbench
===================================

BRAM_READER_2OUT -- requirements
Module: bram_reader_2out

Interface
REQ-001 Parameter width, 120, pixels per line.
REQ-002 Parameter height, 240, lines per frame.
REQ-003 Parameter frame_size, width*height, words per channel per frame.
REQ-004 Parameter addr_bits, $clog2(frame_size), BRAM address width.
REQ-005 Parameter a_width, 13, channel A word width.
REQ-006 Parameter b_width, 8, channel B word width.
REQ-007 Parameter rd_latency, 2, BRAM read latency in cycles (address to data).
REQ-008 clk  input  1  clock; all logic on rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 start  input  1  begin reading one frame; sampled only in ST_IDLE.
REQ-011 bram_index_in  input  1  buffer half to read, latched at start.
REQ-012 idle  output  1  high in ST_IDLE.
REQ-013 rd_bram_index  output  1  latched buffer half, drives BRAM select.
REQ-014 a_rd_address / b_rd_address  output  addr_bits  per-channel read address.
REQ-015 a_rd_ena / b_rd_ena  output  1  per-channel read strobe.
REQ-016 a_rd_data / b_rd_data  input  a_width / b_width  BRAM data, valid rd_latency cycles after the strobe.
REQ-017 a_data, a_valid, a_last  output  a_width,1,1  channel A stream.
REQ-018 a_ready  input  1  channel A consumer ready.
REQ-019 b_data, b_valid, b_last  output  b_width,1,1  channel B stream.
REQ-020 b_ready  input  1  channel B consumer ready.

Function
REQ-021 States: ST_IDLE, ST_RUNNING; idle = (state == ST_IDLE).
REQ-022 ST_IDLE with start: go to ST_RUNNING; clear both addresses, issue counters, output counters and done flags; latch rd_bram_index <= bram_index_in.
REQ-023 start in ST_RUNNING is ignored; rd_bram_index is held constant for the whole frame.
REQ-024 Channels A and B are fully independent: separate address, in-flight counter, output FIFO and done flag; neither channel stalls the other.
REQ-025 Each channel has an output FIFO of depth rd_latency+2 (4 at default), first-word-fall-through; x_valid = FIFO not empty; x_data = FIFO head.
REQ-026 Read issue: x_rd_ena = running, issue count < frame_size, and (FIFO occupancy + reads in flight) < FIFO depth.
REQ-027 On each x_rd_ena, x_rd_address increments by 1; frame_size reads are issued per channel, addresses 0..frame_size-1 in order, with no wrap.
REQ-028 A rd_latency-deep valid shift register tags returning data; a tagged word is pushed into the FIFO exactly rd_latency cycles after its strobe; the FIFO never overflows.
REQ-029 Pop on x_valid && x_ready; a push and a pop in the same cycle leave occupancy unchanged.
REQ-030 With x_ready held high, sustained throughput is 1 word/cycle after an initial latency of rd_latency+1 cycles from start to first x_valid.
REQ-031 x_last = x_valid and head is output word number frame_size-1; exactly one x_last per frame per channel.
REQ-032 x_done sets when the x_last word is popped; when a_done && b_done, state returns to ST_IDLE on the next cycle.
REQ-033 While a word is presented, x_data and x_last stay stable until it is accepted.

Reset
REQ-034 On reset: state ST_IDLE, idle=1, rd_bram_index=0, addresses=0, x_rd_ena=0, x_valid=0, x_last=0, FIFOs emptied, in-flight tags cleared, done flags cleared.
REQ-035 Reset asserted mid-frame aborts the frame; data returning from reads issued before reset is discarded and never appears at the outputs.

Verification
REQ-036 Use width=4, height=2 (frame_size=8); BRAM model with latency 2, word = address + 16*index.
REQ-037 start with bram_index_in=1, both readies high -> a_data 16..23 on consecutive cycles, first a_valid 3 cycles after start, a_last with 23, idle returns 1 cycle after both last words are accepted.
REQ-038 a_ready low for 10 cycles from cycle 4 -> at most 4 reads outstanding; no word lost or duplicated; b stream continues at full rate.
REQ-039 Random 50% ready on both channels -> each stream is exactly 0..7 in order, one last per channel, addresses never exceed 7.
REQ-040 start pulsed again mid-frame with bram_index_in=0 -> ignored; rd_bram_index stays 1.
REQ-041 Reset at cycle 5 of a frame -> valid drops next cycle, stale data is not emitted; a new start yields a clean frame beginning at 0.

Source files
------------

// File: rtl/bram_reader_2out.sv
// Frame reader: streams one frame from two independent BRAM channels (A and B), each through
// a small first-word-fall-through FIFO sized so every read in flight always has a slot to land.
module bram_reader_2out #(
    parameter int unsigned width      = 120,
    parameter int unsigned height     = 240,
    parameter int unsigned frame_size = width * height,
    parameter int unsigned addr_bits  = $clog2(frame_size),
    parameter int unsigned a_width    = 13,
    parameter int unsigned b_width    = 8,
    parameter int unsigned rd_latency = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 bram_index_in,
    output logic                 idle,
    output logic                 rd_bram_index,
    output logic [addr_bits-1:0] a_rd_address,
    output logic                 a_rd_ena,
    input  logic [a_width-1:0]   a_rd_data,
    output logic [addr_bits-1:0] b_rd_address,
    output logic                 b_rd_ena,
    input  logic [b_width-1:0]   b_rd_data,
    output logic [a_width-1:0]   a_data,
    output logic                 a_valid,
    output logic                 a_last,
    input  logic                 a_ready,
    output logic [b_width-1:0]   b_data,
    output logic                 b_valid,
    output logic                 b_last,
    input  logic                 b_ready
);

    localparam int unsigned depth    = rd_latency + 2;
    localparam int unsigned cnt_bits = $clog2(frame_size + 1);
    localparam int unsigned ptr_bits = $clog2(depth);
    localparam int unsigned occ_bits = $clog2(depth + 1);

    localparam logic [cnt_bits-1:0]  frame_cnt = cnt_bits'(frame_size);
    localparam logic [cnt_bits-1:0]  last_idx  = cnt_bits'(frame_size - 1);
    localparam logic [addr_bits-1:0] last_addr = addr_bits'(frame_size - 1);
    localparam logic [ptr_bits-1:0]  last_ptr  = ptr_bits'(depth - 1);
    localparam logic [occ_bits:0]    fifo_cap  = (occ_bits + 1)'(depth);

    typedef enum logic [0:0] {StIdle, StRunning} state_e;

    state_e state_q, state_d;
    logic   running, start_frame;

    logic [cnt_bits-1:0]   a_issued_q, a_popped_q, b_issued_q, b_popped_q;
    logic [addr_bits-1:0]  a_addr_q, b_addr_q;
    logic [rd_latency-1:0] a_vld_q, b_vld_q;
    logic [a_width-1:0]    a_mem_q [depth];
    logic [b_width-1:0]    b_mem_q [depth];
    logic [ptr_bits-1:0]   a_wptr_q, a_rptr_q, b_wptr_q, b_rptr_q;
    logic [occ_bits-1:0]   a_occ_q, b_occ_q;
    logic [occ_bits:0]     a_used, b_used;
    logic                  a_done_q, b_done_q;
    logic                  a_push, a_pop, b_push, b_pop;

    assign running     = (state_q == StRunning);
    assign start_frame = (state_q == StIdle) && start;
    assign idle        = (state_q == StIdle);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StRunning;
            StRunning: if (a_done_q && b_done_q) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            rd_bram_index <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_frame) rd_bram_index <= bram_index_in;
        end
    end

    // Credit check counts reads still in the latency pipe so the FIFO can never overflow.
    always_comb begin
        a_used   = {1'b0, a_occ_q} + (occ_bits + 1)'($countones(a_vld_q));
        b_used   = {1'b0, b_occ_q} + (occ_bits + 1)'($countones(b_vld_q));
        a_rd_ena = running && (a_issued_q < frame_cnt) && (a_used < fifo_cap);
        b_rd_ena = running && (b_issued_q < frame_cnt) && (b_used < fifo_cap);
        a_push   = a_vld_q[rd_latency-1];
        b_push   = b_vld_q[rd_latency-1];
        a_valid  = (a_occ_q != '0);
        b_valid  = (b_occ_q != '0);
        a_data   = a_mem_q[a_rptr_q];
        b_data   = b_mem_q[b_rptr_q];
        a_last   = a_valid && (a_popped_q == last_idx);
        b_last   = b_valid && (b_popped_q == last_idx);
        a_pop    = a_valid && a_ready;
        b_pop    = b_valid && b_ready;
    end

    assign a_rd_address = a_addr_q;
    assign b_rd_address = b_addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_issued_q <= '0;
            a_popped_q <= '0;
            a_addr_q   <= '0;
            a_vld_q    <= '0;
            a_wptr_q   <= '0;
            a_rptr_q   <= '0;
            a_occ_q    <= '0;
            a_done_q   <= 1'b0;
        end else begin
            a_vld_q <= rd_latency'({a_vld_q, a_rd_ena});
            if (start_frame) begin
                a_issued_q <= '0;
                a_popped_q <= '0;
                a_addr_q   <= '0;
                a_done_q   <= 1'b0;
            end else begin
                if (a_rd_ena) begin
                    a_issued_q <= a_issued_q + 1'b1;
                    if (a_addr_q != last_addr) a_addr_q <= a_addr_q + 1'b1;
                end
                if (a_pop) begin
                    a_popped_q <= a_popped_q + 1'b1;
                    if (a_last) a_done_q <= 1'b1;
                end
            end
            if (a_push) a_wptr_q <= (a_wptr_q == last_ptr) ? '0 : a_wptr_q + 1'b1;
            if (a_pop)  a_rptr_q <= (a_rptr_q == last_ptr) ? '0 : a_rptr_q + 1'b1;
            a_occ_q <= a_occ_q + occ_bits'(a_push) - occ_bits'(a_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            b_issued_q <= '0;
            b_popped_q <= '0;
            b_addr_q   <= '0;
            b_vld_q    <= '0;
            b_wptr_q   <= '0;
            b_rptr_q   <= '0;
            b_occ_q    <= '0;
            b_done_q   <= 1'b0;
        end else begin
            b_vld_q <= rd_latency'({b_vld_q, b_rd_ena});
            if (start_frame) begin
                b_issued_q <= '0;
                b_popped_q <= '0;
                b_addr_q   <= '0;
                b_done_q   <= 1'b0;
            end else begin
                if (b_rd_ena) begin
                    b_issued_q <= b_issued_q + 1'b1;
                    if (b_addr_q != last_addr) b_addr_q <= b_addr_q + 1'b1;
                end
                if (b_pop) begin
                    b_popped_q <= b_popped_q + 1'b1;
                    if (b_last) b_done_q <= 1'b1;
                end
            end
            if (b_push) b_wptr_q <= (b_wptr_q == last_ptr) ? '0 : b_wptr_q + 1'b1;
            if (b_pop)  b_rptr_q <= (b_rptr_q == last_ptr) ? '0 : b_rptr_q + 1'b1;
            b_occ_q <= b_occ_q + occ_bits'(b_push) - occ_bits'(b_pop);
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (a_push) a_mem_q[a_wptr_q] <= a_rd_data;
        if (b_push) b_mem_q[b_wptr_q] <= b_rd_data;
    end

endmodule

// File: tb/tb_bram_reader_2out.sv
// Directed bench for bram_reader_2out: 4x2 frame, latency-2 BRAM model (word = addr + 16*index).
module tb_bram_reader_2out;

    localparam int unsigned AW = 13;
    localparam int unsigned BW = 8;

    logic          clk = 1'b0;
    logic          reset, start, bram_index_in;
    logic          idle, rd_bram_index;
    logic [2:0]    a_rd_address, b_rd_address;
    logic          a_rd_ena, b_rd_ena;
    logic [AW-1:0] a_rd_data, a_p1, a_data;
    logic [BW-1:0] b_rd_data, b_p1, b_data;
    logic          a_valid, a_last, a_ready;
    logic          b_valid, b_last, b_ready;

    int n_vec = 0;
    int n_miss = 0;

    // Per-frame observation state
    int      cyc, a_iss, b_iss, a_lasts, b_lasts;
    int      first_a, first_b, a_last_cyc, b_last_cyc, idle_cyc, a_max_out, b_max_out;
    int      a_got[$];
    int      b_got[$];
    bit      a_wait, b_wait, a_wait_last, b_wait_last;
    bit [AW-1:0] a_wait_data;
    bit [BW-1:0] b_wait_data;

    always #5 clk = ~clk;

    bram_reader_2out #(
        .width (4),
        .height(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bram_index_in(bram_index_in),
        .idle         (idle),
        .rd_bram_index(rd_bram_index),
        .a_rd_address (a_rd_address),
        .a_rd_ena     (a_rd_ena),
        .a_rd_data    (a_rd_data),
        .b_rd_address (b_rd_address),
        .b_rd_ena     (b_rd_ena),
        .b_rd_data    (b_rd_data),
        .a_data       (a_data),
        .a_valid      (a_valid),
        .a_last       (a_last),
        .a_ready      (a_ready),
        .b_data       (b_data),
        .b_valid      (b_valid),
        .b_last       (b_last),
        .b_ready      (b_ready)
    );

    // Two-stage BRAM: address captured with the strobe, data out two cycles later.
    always @(posedge clk) begin
        if (a_rd_ena) a_p1 <= {10'd0, a_rd_address} + (rd_bram_index ? 13'd16 : 13'd0);
        if (b_rd_ena) b_p1 <= {5'd0, b_rd_address} + (rd_bram_index ? 8'd16 : 8'd0);
        a_rd_data <= a_p1;
        b_rd_data <= b_p1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic new_frame();
        cyc = 0; a_iss = 0; b_iss = 0; a_lasts = 0; b_lasts = 0;
        first_a = -1; first_b = -1; a_last_cyc = -1; b_last_cyc = -1; idle_cyc = -1;
        a_max_out = 0; b_max_out = 0;
        a_got.delete(); b_got.delete();
        a_wait = 1'b0; b_wait = 1'b0;
    endtask

    // Entered #1 after a rising edge with inputs set; observes one cycle at the falling edge.
    task automatic tick();
        @(negedge clk);
        if (a_rd_ena === 1'b1) begin
            check_eq("a_addr", 32'(a_rd_address), 32'(a_iss));
            a_iss++;
        end
        if (b_rd_ena === 1'b1) begin
            check_eq("b_addr", 32'(b_rd_address), 32'(b_iss));
            b_iss++;
        end
        if (a_wait) check_eq("a_hold", 32'({a_valid, a_last, a_data}),
                             32'({1'b1, a_wait_last, a_wait_data}));
        if (b_wait) check_eq("b_hold", 32'({b_valid, b_last, b_data}),
                             32'({1'b1, b_wait_last, b_wait_data}));
        a_wait = a_valid && !a_ready; a_wait_data = a_data; a_wait_last = a_last;
        b_wait = b_valid && !b_ready; b_wait_data = b_data; b_wait_last = b_last;
        if (a_valid === 1'b1 && first_a < 0) first_a = cyc;
        if (b_valid === 1'b1 && first_b < 0) first_b = cyc;
        if (a_valid === 1'b1 && a_ready) begin
            a_got.push_back(int'(a_data));
            if (a_last) begin a_lasts++; a_last_cyc = cyc; end
        end
        if (b_valid === 1'b1 && b_ready) begin
            b_got.push_back(int'(b_data));
            if (b_last) begin b_lasts++; b_last_cyc = cyc; end
        end
        if (a_iss - a_got.size() > a_max_out) a_max_out = a_iss - a_got.size();
        if (b_iss - b_got.size() > b_max_out) b_max_out = b_iss - b_got.size();
        if (idle === 1'b1 && idle_cyc < 0) idle_cyc = cyc;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input bit idx);
        bram_index_in = idx;
        start = 1'b1;
        tick();
        start = 1'b0;
        new_frame();
    endtask

    // mode 0: ready high; 1: a stalls cycles 4..13 plus a start pulse at 6; 2: random ready
    task automatic run_frame(input int mode, input int limit);
        while (idle_cyc < 0 && cyc < limit) begin
            case (mode)
                1: begin
                    a_ready = !(cyc >= 4 && cyc <= 13);
                    start = (cyc == 6);
                    if (cyc == 6) bram_index_in = 1'b0;
                end
                2: begin
                    a_ready = 1'($urandom_range(0, 1));
                    b_ready = 1'($urandom_range(0, 1));
                end
                default: ;
            endcase
            tick();
        end
        start = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
        check_eq("frame_ends", 32'(idle_cyc >= 0), 32'd1);
    endtask

    task automatic check_frame(input bit idx);
        check_eq("a_count", 32'(a_got.size()), 32'd8);
        check_eq("b_count", 32'(b_got.size()), 32'd8);
        for (int i = 0; i < 8 && i < a_got.size(); i++)
            check_eq("a_word", 32'(a_got[i]), 32'(i + 16 * int'(idx)));
        for (int i = 0; i < 8 && i < b_got.size(); i++)
            check_eq("b_word", 32'(b_got[i]), 32'(i + 16 * int'(idx)));
        check_eq("a_lasts", 32'(a_lasts), 32'd1);
        check_eq("b_lasts", 32'(b_lasts), 32'd1);
        check_eq("a_issued", 32'(a_iss), 32'd8);
        check_eq("b_issued", 32'(b_iss), 32'd8);
        check_eq("bram_index", 32'(rd_bram_index), 32'(idx));
    endtask

    task automatic check_full_rate();
        check_eq("a_first", 32'(first_a), 32'd3);
        check_eq("b_first", 32'(first_b), 32'd3);
        check_eq("a_last_cyc", 32'(a_last_cyc), 32'd10);
        check_eq("b_last_cyc", 32'(b_last_cyc), 32'd10);
        check_eq("idle_cyc", 32'(idle_cyc), 32'd12);
    endtask

    initial begin
        int stray;
        reset = 1'b1; start = 1'b0; bram_index_in = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
        new_frame();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_eq("rst_idle", 32'(idle), 32'd1);
        check_eq("rst_index", 32'(rd_bram_index), 32'd0);
        check_eq("rst_valid", 32'({a_valid, b_valid, a_last, b_last}), 32'd0);
        check_eq("rst_ena", 32'({a_rd_ena, b_rd_ena}), 32'd0);
        check_eq("rst_addr", 32'({a_rd_address, b_rd_address}), 32'd0);

        // Full-rate frame from buffer half 1
        start_frame(1'b1);
        run_frame(0, 100);
        check_full_rate();
        check_frame(1'b1);

        // A stalls; B keeps full rate; mid-frame start is ignored
        start_frame(1'b1);
        run_frame(1, 100);
        check_eq("stall_b_last", 32'(b_last_cyc), 32'd10);
        check_eq("stall_a_last", 32'(a_last_cyc), 32'd20);
        check_eq("stall_idle", 32'(idle_cyc), 32'd22);
        check_eq("stall_a_out", 32'(a_max_out), 32'd4);
        check_frame(1'b1);

        // Random backpressure on both channels, buffer half 0
        start_frame(1'b0);
        run_frame(2, 400);
        check_eq("rand_a_out", 32'(a_max_out <= 4), 32'd1);
        check_eq("rand_b_out", 32'(b_max_out <= 4), 32'd1);
        check_frame(1'b0);

        // Reset at cycle 5 of a frame, then a clean frame
        start_frame(1'b1);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("abort_valid", 32'({a_valid, b_valid}), 32'd0);
        check_eq("abort_idle", 32'(idle), 32'd1);
        check_eq("abort_index", 32'(rd_bram_index), 32'd0);
        new_frame();
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (a_valid !== 1'b0 || b_valid !== 1'b0 || a_rd_ena !== 1'b0) stray++;
        end
        check_eq("abort_stale", 32'(stray), 32'd0);
        check_eq("abort_words", 32'(a_got.size() + b_got.size()), 32'd0);
        start_frame(1'b0);
        run_frame(0, 100);
        check_full_rate();
        check_frame(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
